// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline operand-forwarding slice.
package pipe_pkg;
   localparam int unsigned WIDTH_DEF   = 32;
   localparam int unsigned AW_DEF      = 5;
   localparam int unsigned NUM_FWD_DEF = 3;
   localparam int unsigned ZERO_REG    = 0;
   localparam int unsigned REG31       = 31;
   localparam int unsigned SRC_RF      = NUM_FWD_DEF;

   // Width of a source index that can also encode "register file" (value n).
   function automatic int unsigned src_w(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/pipe_fwd_operand_if.sv
// ID-side operand request, forwarding sources and EX-side operand result.
interface pipe_fwd_operand_if
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned NUM_FWD = NUM_FWD_DEF,
   parameter int unsigned SW      = src_w(NUM_FWD)
) ();
   logic                     stall;
   logic                     flush;
   logic                     in_valid;
   logic [AW-1:0]            raddr;
   logic [WIDTH-1:0]         rf_data;
   logic [NUM_FWD*AW-1:0]    fwd_addr;
   logic [NUM_FWD-1:0]       fwd_we;
   logic [NUM_FWD-1:0]       fwd_rdy;
   logic [NUM_FWD*WIDTH-1:0] fwd_data;
   logic                     hazard;
   logic                     out_valid;
   logic [WIDTH-1:0]         out_data;
   logic [SW-1:0]            out_src;

   modport master (
      output stall, flush, in_valid, raddr, rf_data, fwd_addr, fwd_we, fwd_rdy, fwd_data,
      input  hazard, out_valid, out_data, out_src
   );
   modport slave (
      input  stall, flush, in_valid, raddr, rf_data, fwd_addr, fwd_we, fwd_rdy, fwd_data,
      output hazard, out_valid, out_data, out_src
   );
endinterface

// File: rtl/fwd_prio_sel.sv
// Priority forwarding selector: lowest-index matching writer wins over the RF.
module fwd_prio_sel
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned NUM_FWD  = NUM_FWD_DEF,
   parameter int unsigned ZERO_REG = pipe_pkg::ZERO_REG,
   parameter int unsigned SW       = src_w(NUM_FWD)
) (
   input  logic [AW-1:0]            raddr_i,
   input  logic [WIDTH-1:0]         rf_data_i,
   input  logic [NUM_FWD*AW-1:0]    fwd_addr_i,
   input  logic [NUM_FWD-1:0]       fwd_we_i,
   input  logic [NUM_FWD-1:0]       fwd_rdy_i,
   input  logic [NUM_FWD*WIDTH-1:0] fwd_data_i,
   output logic                     found_o,
   output logic [SW-1:0]            winner_o,
   output logic                     win_rdy_o,
   output logic [WIDTH-1:0]         resolved_o
);
   logic             is_zero;
   logic [WIDTH-1:0] win_data;

   assign is_zero = (raddr_i == AW'(ZERO_REG));

   // Scan from lowest priority up so the youngest matching stage overrides.
   always_comb begin
      found_o   = 1'b0;
      winner_o  = SW'(NUM_FWD);
      win_rdy_o = 1'b0;
      win_data  = '0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_we_i[i] && (fwd_addr_i[i*AW +: AW] == raddr_i) && !is_zero) begin
            found_o   = 1'b1;
            winner_o  = SW'(i);
            win_rdy_o = fwd_rdy_i[i];
            win_data  = fwd_data_i[i*WIDTH +: WIDTH];
         end
      end
   end

   assign resolved_o = (found_o && win_rdy_o) ? win_data :
                       (is_zero ? '0 : rf_data_i);
endmodule

// File: rtl/pipe_fwd_operand.sv
// One forwarded source operand registered from ID into EX, with stall-sticky capture.
module pipe_fwd_operand
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned NUM_FWD  = NUM_FWD_DEF,
   parameter int unsigned ZERO_REG = pipe_pkg::ZERO_REG
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_fwd_operand_if.slave  bus
);
   localparam int unsigned   SW     = src_w(NUM_FWD);
   localparam logic [SW-1:0] SRC_RF = SW'(NUM_FWD);

   logic             found, win_rdy, hazard_c, cap_hit;
   logic [SW-1:0]    winner, res_src;
   logic [WIDTH-1:0] resolved;

   logic             cap_valid_q, cap_valid_d;
   logic [WIDTH-1:0] cap_data_q,  cap_data_d;
   logic [AW-1:0]    cap_addr_q,  cap_addr_d;
   logic [SW-1:0]    cap_src_q,   cap_src_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SW-1:0]    out_src_q,   out_src_d;

   fwd_prio_sel #(
      .WIDTH(WIDTH), .AW(AW), .NUM_FWD(NUM_FWD), .ZERO_REG(ZERO_REG), .SW(SW)
   ) u_sel (
      .raddr_i    (bus.raddr),
      .rf_data_i  (bus.rf_data),
      .fwd_addr_i (bus.fwd_addr),
      .fwd_we_i   (bus.fwd_we),
      .fwd_rdy_i  (bus.fwd_rdy),
      .fwd_data_i (bus.fwd_data),
      .found_o    (found),
      .winner_o   (winner),
      .win_rdy_o  (win_rdy),
      .resolved_o (resolved)
   );

   assign hazard_c   = bus.in_valid && found && !win_rdy;
   assign res_src    = (found && win_rdy) ? winner : SRC_RF;
   assign cap_hit    = cap_valid_q && (cap_addr_q == bus.raddr);
   assign bus.hazard = hazard_c;

   // A capture whose address no longer matches is treated as absent and refilled.
   always_comb begin
      cap_valid_d = cap_valid_q;
      cap_data_d  = cap_data_q;
      cap_addr_d  = cap_addr_q;
      cap_src_d   = cap_src_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;

      if (bus.flush || !bus.stall) begin
         cap_valid_d = 1'b0;
      end else if (bus.in_valid && !hazard_c && !cap_hit) begin
         cap_valid_d = 1'b1;
         cap_data_d  = resolved;
         cap_addr_d  = bus.raddr;
         cap_src_d   = res_src;
      end

      if (bus.flush) begin
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_src_d   = SRC_RF;
      end else if (!bus.stall) begin
         out_valid_d = bus.in_valid && !hazard_c;
         out_data_d  = cap_hit ? cap_data_q : resolved;
         out_src_d   = cap_hit ? cap_src_q  : res_src;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_valid_q <= 1'b0;
         cap_data_q  <= '0;
         cap_addr_q  <= '0;
         cap_src_q   <= SRC_RF;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= SRC_RF;
      end else begin
         cap_valid_q <= cap_valid_d;
         cap_data_q  <= cap_data_d;
         cap_addr_q  <= cap_addr_d;
         cap_src_q   <= cap_src_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_pipe_fwd_operand.sv
// Directed vector bench for pipe_fwd_operand (WIDTH=32, AW=5, NUM_FWD=3).
module tb_pipe_fwd_operand;
   import pipe_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec = 0;
   int   n_bad = 0;

   pipe_fwd_operand_if #(.WIDTH(32), .AW(5), .NUM_FWD(3)) bus ();

   pipe_fwd_operand #(.WIDTH(32), .AW(5), .NUM_FWD(3), .ZERO_REG(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        inv;
      logic [4:0]  raddr;
      logic [31:0] rf;
      logic [4:0]  a0, a1, a2;
      logic [2:0]  we, rdy;
      logic [31:0] d0, d1, d2;
      logic        ehz, evld;
      logic [31:0] edat;
      logic [1:0]  esrc;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic drv(input logic st, input logic fl, input logic inv,
                      input logic [4:0] ra, input logic [31:0] rf,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [2:0] we, input logic [2:0] rdy,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
      bus.stall    = st;
      bus.flush    = fl;
      bus.in_valid = inv;
      bus.raddr    = ra;
      bus.rf_data  = rf;
      bus.fwd_addr = {a2, a1, a0};
      bus.fwd_we   = we;
      bus.fwd_rdy  = rdy;
      bus.fwd_data = {d2, d1, d0};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string nm, input logic v, input logic [31:0] d, input logic [1:0] s);
      check({nm, "_valid"}, {31'b0, bus.out_valid}, {31'b0, v});
      check({nm, "_data"},  bus.out_data, d);
      check({nm, "_src"},   {30'b0, bus.out_src}, {30'b0, s});
   endtask

   // Plain RF read with no forwarding activity.
   task automatic drv_rf(input logic st, input logic fl, input logic [4:0] ra, input logic [31:0] rf);
      drv(st, fl, 1'b1, ra, rf, 5'd0, 5'd0, 5'd0, 3'b000, 3'b111, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      tbl[0] = '{1'b1, 5'd8,  32'h1,    5'd8, 5'd3,  5'd8,  3'b101, 3'b111, 32'hAAAA, 32'hBBBB, 32'hCCCC,     1'b0, 1'b1, 32'hAAAA,     2'd0};
      tbl[1] = '{1'b1, 5'd0,  32'hDEAD, 5'd0, 5'd3,  5'd4,  3'b001, 3'b111, 32'h1234, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0,        2'd3};
      tbl[2] = '{1'b1, 5'd7,  32'h7777, 5'd1, 5'd2,  5'd3,  3'b111, 3'b111, 32'h1,    32'h2,    32'h3,        1'b0, 1'b1, 32'h7777,     2'd3};
      tbl[3] = '{1'b1, 5'd12, 32'h0,    5'd3, 5'd12, 5'd12, 3'b111, 3'b111, 32'h0,    32'hB0B0, 32'hC0C0,     1'b0, 1'b1, 32'hB0B0,     2'd1};
      tbl[4] = '{1'b1, 5'(REG31), 32'h1F, 5'd1, 5'd2, 5'(REG31), 3'b111, 3'b111, 32'h0, 32'h0, 32'hFFFF0000, 1'b0, 1'b1, 32'hFFFF0000, 2'd2};
      tbl[5] = '{1'b1, 5'd4,  32'h40,   5'd1, 5'd4,  5'd4,  3'b111, 3'b101, 32'h0,    32'h0,    32'h44,       1'b1, 1'b0, 32'h40,       2'd3};
      tbl[6] = '{1'b0, 5'd4,  32'h40,   5'd4, 5'd0,  5'd0,  3'b001, 3'b000, 32'h0,    32'h0,    32'h0,        1'b0, 1'b0, 32'h40,       2'd3};
      tbl[7] = '{1'b1, 5'd6,  32'h60,   5'd6, 5'd6,  5'd0,  3'b010, 3'b111, 32'h61,   32'h66,   32'h0,        1'b0, 1'b1, 32'h66,       2'd1};
      tbl[8] = '{1'b1, 5'd0,  32'h99,   5'd0, 5'd0,  5'd0,  3'b111, 3'b000, 32'h5,    32'h5,    32'h5,        1'b0, 1'b1, 32'h0,        2'd3};

      rst_n = 1'b0;
      drv_rf(1'b0, 1'b0, 5'd1, 32'h5A5A);
      repeat (2) tick();
      check_out("reset", 1'b0, 32'h0, 2'd3);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         drv(1'b0, 1'b0, tbl[i].inv, tbl[i].raddr, tbl[i].rf, tbl[i].a0, tbl[i].a1, tbl[i].a2,
             tbl[i].we, tbl[i].rdy, tbl[i].d0, tbl[i].d1, tbl[i].d2);
         #1;
         check($sformatf("v%0d_hazard", i), {31'b0, bus.hazard}, {31'b0, tbl[i].ehz});
         tick();
         check_out($sformatf("v%0d", i), tbl[i].evld, tbl[i].edat, tbl[i].esrc);
      end

      // Load-use: fwd0 load in flight, then ready while stalled, then retires.
      drv_rf(1'b0, 1'b0, 5'd20, 32'h2020);
      tick();
      check_out("pre_lu", 1'b1, 32'h2020, 2'd3);
      drv(1'b1, 1'b0, 1'b1, 5'd5, 32'h05, 5'd5, 5'd5, 5'd0, 3'b011, 3'b010, 32'h0, 32'h50, 32'h0);
      #1;
      check("lu_hazard", {31'b0, bus.hazard}, 32'd1);
      tick();
      check_out("lu_hold", 1'b1, 32'h2020, 2'd3);
      drv(1'b1, 1'b0, 1'b1, 5'd5, 32'h05, 5'd5, 5'd5, 5'd0, 3'b011, 3'b011, 32'h55, 32'h50, 32'h0);
      #1;
      check("lu_rdy_hazard", {31'b0, bus.hazard}, 32'd0);
      tick();
      drv(1'b1, 1'b0, 1'b1, 5'd5, 32'h05, 5'd2, 5'd5, 5'd0, 3'b010, 3'b010, 32'h0, 32'h55, 32'h0);
      tick();
      check_out("lu_hold2", 1'b1, 32'h2020, 2'd3);
      drv_rf(1'b0, 1'b0, 5'd5, 32'h05);
      tick();
      check_out("lu_release", 1'b1, 32'h55, 2'd0);

      // WB source retires during a 3-cycle stall while RF still shows the stale value.
      drv(1'b1, 1'b0, 1'b1, 5'd9, 32'h11, 5'd0, 5'd0, 5'd9, 3'b100, 3'b111, 32'h0, 32'h0, 32'h99);
      tick();
      drv_rf(1'b1, 1'b0, 5'd9, 32'h11);
      repeat (2) tick();
      drv_rf(1'b0, 1'b0, 5'd9, 32'h11);
      tick();
      check_out("wb_retire", 1'b1, 32'h99, 2'd2);

      // Flush together with stall clears the capture and loads a bubble.
      drv_rf(1'b1, 1'b0, 5'd10, 32'hA0);
      tick();
      drv_rf(1'b1, 1'b1, 5'd10, 32'hA1);
      tick();
      check_out("flush", 1'b0, 32'h0, 2'd3);
      drv_rf(1'b0, 1'b0, 5'd10, 32'hA2);
      tick();
      check_out("post_flush", 1'b1, 32'hA2, 2'd3);

      // Address change mid-stall makes the capture stale and triggers a re-capture.
      drv_rf(1'b1, 1'b0, 5'd13, 32'h13);
      tick();
      drv_rf(1'b1, 1'b0, 5'd14, 32'h14);
      tick();
      drv_rf(1'b0, 1'b0, 5'd14, 32'h15);
      tick();
      check_out("recapture", 1'b1, 32'h14, 2'd3);

      // Reset during a stall discards the capture.
      drv_rf(1'b1, 1'b0, 5'd16, 32'h16);
      tick();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      drv_rf(1'b0, 1'b0, 5'd16, 32'h17);
      tick();
      check_out("rst_stall", 1'b1, 32'h17, 2'd3);

      // Asynchronous reset mid-cycle; hazard stays combinational on the inputs.
      drv_rf(1'b0, 1'b0, 5'd21, 32'h2121);
      tick();
      check_out("pre_arst", 1'b1, 32'h2121, 2'd3);
      drv(1'b0, 1'b0, 1'b1, 5'd4, 32'h40, 5'd4, 5'd0, 5'd0, 3'b001, 3'b000, 32'h0, 32'h0, 32'h0);
      #1;
      rst_n = 1'b0;
      #1;
      check_out("arst", 1'b0, 32'h0, 2'd3);
      check("arst_hazard", {31'b0, bus.hazard}, 32'd1);
      rst_n = 1'b1;
      tick();
      check_out("arst_bubble", 1'b0, 32'h40, 2'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
